mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single data-memory/device bus between two requesters: port 0 is the CPU MEM stage, port 1 is the boot loader/DMA engine.
- Round-robin arbitration, with one transaction in flight at a time.
- Handles reads from a fixed-latency memory and returns the read data to the winning port.
- Sits between the CPU top level and the data memory/device bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request (level).
- we0  in  1  port 0 write=1, read=0.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant pulse.
- rvalid0  out  1  port 0 read data valid pulse.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  out  DATA_W  registered read data, shared by both ports.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from req to any output.

Reset:
- reset=1, asynchronous: state=IDLE, last_grant=1.
- All outputs 0: gnt*, rvalid*, rdata, mem_*, busy.
- The latched command is cleared, the wait counter is 0, and any pending read is dropped with no rvalid.

States: IDLE, ISSUE, WAIT.

IDLE:
- At each rising edge, req0/req1 are sampled.
- None set: stay in IDLE.
- One set: that port wins.
- Both set: the port != last_grant wins. Port 0 wins first after reset.
- On a win: latch owner, we, addr, wdata; set last_grant=owner; go to ISSUE.

ISSUE (exactly 1 cycle):
- mem_addr = latched addr.
- Write: mem_write=1 and mem_wdata = latched wdata.
- Read: mem_read=1.
- gnt[owner]=1 for this cycle only.
- Write: next state IDLE; the write is complete.
- Read: next state WAIT, counter loaded with RD_LAT.

WAIT:
- mem_read=0 and mem_write=0; mem_addr holds its value.
- The counter decrements each cycle.
- mem_rdata is valid in the cycle at ISSUE+RD_LAT. It is captured into rdata at the end of that cycle, and the state moves to IDLE.

Read response:
- rvalid[owner]=1 for exactly one cycle, at ISSUE+RD_LAT+1.
- The arbiter is already in IDLE during that cycle and samples new requests at its end.
- rdata holds its value until the next read capture.

Requester rules:
- addr, we and wdata must be stable while req is high.
- The requester drops req at the edge following gnt.
- A req still high when the arbiter returns to IDLE is treated as a new request.

Timing and boundary conditions:
- Write occupancy: 2 cycles, IDLE-sample then ISSUE.
- Read occupancy: RD_LAT+1 cycles after the sample.
- Maximum wait for a requester with both ports saturated: one other transaction.
- A request arriving during ISSUE or WAIT is not lost. It is served on return to IDLE, with round-robin order preserved.
- A requester dropping req before grant is legal; nothing is issued for it.
- gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.
- mem_read and mem_write are never high together.
- Reset asserted mid-WAIT: immediate return to IDLE, no rvalid, last_grant=1.

Test Plan:
- Reset, then req0 alone writing addr=0x40000010, wdata=0x0000CAFE -> one cycle later mem_write=1 with that address and data, gnt0=1 for 1 cycle; busy=1 for 1 cycle; gnt1 stays 0.
- RD_LAT=2, req1 read at addr=0x100, memory returns 0x12345678 in cycle ISSUE+2 -> gnt1 at ISSUE; rvalid1=1 and rdata=0x12345678 at ISSUE+3; rvalid0 stays 0.
- req0 and req1 both held high continuously, each performing writes -> grant order 0,1,0,1; exactly one ISSUE per 2 cycles; each port gets a gnt every 4 cycles.
- Port 0 read in WAIT (RD_LAT=3) while req1 is raised -> port 1 is granted only after port 0's data capture, in the ISSUE cycle following the IDLE in which rvalid0 is high.
- Reset pulsed during WAIT of a read -> all outputs 0 immediately; no rvalid afterwards; with both ports then requesting, the next grant goes to port 0.
- RD_LAT=1, back-to-back port 0 reads 0x0, 0x4 returning 0xA and 0xB -> rvalid0 with rdata=0xA, then rvalid0 with rdata=0xB three cycles later; mem_read and mem_write never high together.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port round-robin arbiter for the data memory bus
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state;
  logic       last_grant;
  logic       owner;
  logic       cmd_we;
  logic [2:0] cnt;

  logic pick;
  logic sel_we;

  // On contention the port that did not win last time goes next
  assign pick   = (req0 && req1) ? ~last_grant : req1;
  assign sel_we = pick ? we1 : we0;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_we     <= 1'b0;
      cnt        <= 3'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata      <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= pick;
            last_grant <= pick;
            cmd_we     <= sel_we;
            mem_addr   <= pick ? addr1 : addr0;
            if (sel_we) begin
              mem_wdata <= pick ? wdata1 : wdata0;
            end
            mem_write <= sel_we;
            mem_read  <= ~sel_we;
            gnt0      <= ~pick;
            gnt1      <= pick;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state <= IDLE;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Last wait cycle is the one where memory presents the read data
          if (cnt == 3'd1) begin
            rdata   <= mem_rdata;
            rvalid0 <= ~owner;
            rvalid1 <= owner;
            cnt     <= 3'd0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r [2];
  logic        w [2];
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int iss_cycle = -1;
  int iss_port = 0;
  int idle_from = 0;
  int rv_cycle = -1;
  int rv_port = 0;
  int last = 1;
  logic        iss_we = 1'b0;
  logic [31:0] iss_addr = 0, iss_wdata = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rdata = 0, prev_mdata = 0;

  int exp_order [4] = '{0, 1, 0, 1};
  int got_order [$];

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(r[0]), .we0(w[0]), .addr0(a[0]), .wdata0(d[0]), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(r[1]), .we1(w[1]), .addr1(a[1]), .wdata1(d[1]), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    iss_cycle = -1;
    rv_cycle  = -1;
    idle_from = 0;
    last      = 1;
    exp_addr  = 0;
    exp_wdata = 0;
    exp_rdata = 0;
  endtask

  // Transaction-level timeline: a grant decided at the end of cycle k issues in k+1
  task automatic model_sample();
    int win;
    if (cyc >= idle_from && (r[0] || r[1])) begin
      if (r[0] && r[1]) win = (last == 1) ? 0 : 1;
      else win = r[1] ? 1 : 0;
      last      = win;
      iss_cycle = cyc + 1;
      iss_port  = win;
      iss_we    = w[win];
      iss_addr  = a[win];
      iss_wdata = d[win];
      if (w[win]) begin
        idle_from = cyc + 2;
      end else begin
        idle_from = cyc + 2 + LAT;
        rv_cycle  = cyc + 2 + LAT;
        rv_port   = win;
      end
    end
  endtask

  task automatic check_outputs();
    logic iss;
    iss = (cyc == iss_cycle);
    if (iss) begin
      exp_addr = iss_addr;
      if (iss_we) exp_wdata = iss_wdata;
    end
    if (cyc == rv_cycle) exp_rdata = prev_mdata;
    chk1("gnt0", gnt0, iss && iss_port == 0);
    chk1("gnt1", gnt1, iss && iss_port == 1);
    chk1("mem_write", mem_write, iss && iss_we);
    chk1("mem_read", mem_read, iss && !iss_we);
    chk1("busy", busy, cyc >= iss_cycle && cyc < idle_from);
    chk1("rvalid0", rvalid0, cyc == rv_cycle && rv_port == 0);
    chk1("rvalid1", rvalid1, cyc == rv_cycle && rv_port == 1);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("rdata", rdata, exp_rdata);
    chk1("dual_gnt", gnt0 & gnt1, 1'b0);
    chk1("dual_rvalid", rvalid0 & rvalid1, 1'b0);
    chk1("dual_mem", mem_read & mem_write, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_sample();
    prev_mdata = mem_rdata;
    cyc++;
    #2;
    check_outputs();
    mem_rdata = $urandom;
  endtask

  task automatic pulse_reset_mid();
    #1 reset = 1'b1;
    model_reset();
    #1 check_outputs();
  endtask

  task automatic drive_random(input int p_req, input bit hold);
    for (int p = 0; p < 2; p++) begin
      if (r[p] && !hold && cyc == iss_cycle && iss_port == p) begin
        r[p] = 1'b0;
      end else if (!r[p]) begin
        if ($urandom_range(99) < p_req) begin
          r[p] = 1'b1;
          w[p] = 1'($urandom_range(1));
          a[p] = $urandom;
          d[p] = $urandom;
        end
      end else if (!hold && $urandom_range(99) < 2) begin
        r[p] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      r[p] = 1'b0; w[p] = 1'b0; a[p] = 0; d[p] = 0;
    end
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    // Single write from port 0
    r[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h40000010; d[0] = 32'h0000CAFE;
    tick();
    chk1("t1_mem_write", mem_write, 1'b1);
    chk("t1_addr", mem_addr, 32'h40000010);
    chk("t1_wdata", mem_wdata, 32'h0000CAFE);
    chk1("t1_gnt0", gnt0, 1'b1);
    chk1("t1_gnt1", gnt1, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    r[0] = 1'b0;
    tick();
    chk1("t1_busy_end", busy, 1'b0);
    chk1("t1_gnt0_end", gnt0, 1'b0);

    // Port 1 read with data at ISSUE+LAT
    r[1] = 1'b1; w[1] = 1'b0; a[1] = 32'h100;
    tick();
    chk1("t2_gnt1", gnt1, 1'b1);
    chk1("t2_mem_read", mem_read, 1'b1);
    r[1] = 1'b0;
    tick();
    tick();
    mem_rdata = 32'h12345678;
    tick();
    chk1("t2_rvalid1", rvalid1, 1'b1);
    chk("t2_rdata", rdata, 32'h12345678);
    chk1("t2_rvalid0", rvalid0, 1'b0);

    // Both ports saturated with writes
    r[0] = 1'b1; w[0] = 1'b1; a[0] = 32'hA0; d[0] = 32'h1111;
    r[1] = 1'b1; w[1] = 1'b1; a[1] = 32'hB0; d[1] = 32'h2222;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt0) got_order.push_back(0);
      if (gnt1) got_order.push_back(1);
    end
    r[0] = 1'b0; r[1] = 1'b0;
    chk("t3_count", 32'(got_order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_order.size()) chk("t3_order", 32'(got_order[i]), 32'(exp_order[i]));
    end

    // Port 1 raised while port 0 read is waiting
    tick();
    tick();
    r[0] = 1'b1; w[0] = 1'b0; a[0] = 32'h200;
    tick();
    chk1("t4_gnt0", gnt0, 1'b1);
    r[0] = 1'b0; r[1] = 1'b1; w[1] = 1'b1; a[1] = 32'h300; d[1] = 32'h55;
    tick();
    chk1("t4_wait_gnt1", gnt1, 1'b0);
    tick();
    tick();
    chk1("t4_rvalid0", rvalid0, 1'b1);
    chk1("t4_early_gnt1", gnt1, 1'b0);
    tick();
    chk1("t4_gnt1", gnt1, 1'b1);
    r[1] = 1'b0;
    tick();

    // Reset in the middle of a read wait
    r[0] = 1'b1; w[0] = 1'b0; a[0] = 32'h400;
    tick();
    r[0] = 1'b0;
    tick();
    pulse_reset_mid();
    chk1("t5_busy", busy, 1'b0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    r[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h500; d[0] = 32'h5;
    r[1] = 1'b1; w[1] = 1'b1; a[1] = 32'h600; d[1] = 32'h6;
    tick();
    tick();
    chk1("t5_no_rvalid0", rvalid0, 1'b0);
    reset = 1'b0;
    tick();
    chk1("t5_gnt0", gnt0, 1'b1);
    r[0] = 1'b0;
    tick();
    tick();
    chk1("t5_gnt1", gnt1, 1'b1);
    r[1] = 1'b0;
    tick();

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(199) == 0) begin
        pulse_reset_mid();
        tick();
        reset = 1'b0;
      end else begin
        drive_random(40, i >= 600 && i < 800);
      end
    end
    r[0] = 1'b0; r[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
